gray_fifo_ctrl: RTL and testbench
=================================

GRAY_FIFO_CTRL -- requirements
Module: gray_fifo_ctrl

Interface
REQ-001 The block SHALL have one parameter, ADDR_W, default 4: FIFO depth is 2^ADDR_W entries; ADDR_W SHALL be 2..8.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wr_req  input  1  write request from the producer.
REQ-005 rd_req  input  1  read request from the consumer.
REQ-006 wr_en  output  1  storage write strobe (combinational), = wr_req & ~full.
REQ-007 rd_en  output  1  storage read strobe (combinational), = rd_req & ~empty.
REQ-008 wr_addr  output  ADDR_W  storage write address: the low ADDR_W bits of the binary write pointer.
REQ-009 rd_addr  output  ADDR_W  storage read address: the low ADDR_W bits of the binary read pointer.
REQ-010 wr_ptr_gray  output  ADDR_W+1  registered Gray code of the binary write pointer.
REQ-011 rd_ptr_gray  output  ADDR_W+1  registered Gray code of the binary read pointer.
REQ-012 full  output  1  registered; FIFO holds 2^ADDR_W entries.
REQ-013 empty  output  1  registered; FIFO holds 0 entries.
REQ-014 count  output  ADDR_W+1  registered occupancy, 0..2^ADDR_W.
REQ-015 ovf  output  1  sticky; set when wr_req is asserted while full.
REQ-016 unf  output  1  sticky; set when rd_req is asserted while empty.

Function
REQ-017 The binary write and read pointers SHALL each be ADDR_W+1 bits wide and SHALL wrap modulo 2^(ADDR_W+1).
REQ-018 The write pointer SHALL increment by 1 on every cycle with wr_en=1; the read pointer SHALL increment by 1 on every cycle with rd_en=1.
REQ-019 Gray encoding SHALL be g = b ^ (b >> 1): MSB passed through, each lower bit the XOR of adjacent binary bits.
REQ-020 wr_ptr_gray and rd_ptr_gray SHALL be registered and SHALL reflect the updated pointer in the cycle after the increment.
REQ-021 Consecutive values of each Gray pointer SHALL differ in exactly one bit, including across the wrap from all-ones to zero.
REQ-022 empty SHALL be 1 when the write and read Gray pointers are equal.
REQ-023 full SHALL be 1 when the two MSBs of the write Gray pointer are the inverse of the two MSBs of the read Gray pointer and all lower bits are equal.
REQ-024 full, empty and count SHALL be derived from the next-state pointers so that they are valid in the same cycle as the updated pointers (no extra cycle of lag).
REQ-025 count SHALL equal wr_bin - rd_bin, computed modulo 2^(ADDR_W+1).
REQ-026 Simultaneous wr_en and rd_en SHALL advance both pointers and leave count, full and empty unchanged.
REQ-027 When full, a simultaneous read and write SHALL perform only the read, because wr_en is gated by the current full.
REQ-028 When empty, a simultaneous read and write SHALL perform only the write, because rd_en is gated by the current empty.
REQ-029 ovf and unf SHALL be set one cycle after the offending request and SHALL hold until reset.
REQ-030 A blocked request SHALL NOT move any pointer.

Reset
REQ-031 While rst=1, both pointers SHALL be forced to 0 and both Gray outputs to 0.
REQ-032 While rst=1, the outputs SHALL be count=0, empty=1, full=0, ovf=0 and unf=0.
REQ-033 Reset SHALL take priority over any wr_req/rd_req in the same cycle.
REQ-034 A reset asserted mid-operation SHALL discard the occupancy; the first cycle after rst falls SHALL behave as an empty FIFO.
REQ-035 While rst=1, wr_en and rd_en SHALL be 0.

Verification
REQ-036 Reset, then idle: after rst drops, expect empty=1, full=0, count=0, wr_ptr_gray=rd_ptr_gray=5'b00000.
REQ-037 Gray sequence (ADDR_W=4): write 16 entries, then read 16, repeated twice, so the pointers wrap.
  - Each cycle, check wr_ptr_gray = {b[4], b[4]^b[3], b[3]^b[2], b[2]^b[1], b[1]^b[0]}.
  - Check that exactly one bit changes per increment, including the 5'b10000 -> 5'b00000 wrap.
REQ-038 Fill to full: 16 writes -> full=1, count=16, wr_ptr_gray=5'b11000.
  - A 17th wr_req gives wr_en=0, the pointer unchanged, and ovf=1 the next cycle.
REQ-039 Empty read: with the FIFO empty, rd_req=1 -> rd_en=0, rd_ptr_gray unchanged, unf=1 the next cycle.
  - A simultaneous wr_req in that cycle still writes, so count=1.
REQ-040 Concurrent traffic: with count=5, apply wr_req=rd_req=1 for 20 cycles -> count stays 5, and both pointers advance 20 and wrap.
  - At full, wr_req=rd_req=1 -> only the read occurs, so count=15 and full=0.
REQ-041 Reset mid-stream: at count=9, assert rst together with wr_req=1 -> the next cycle shows count=0, empty=1, ovf=unf=0, and both pointers at 0.

Source files
------------

// File: rtl/gray_fifo_ctrl_if.sv
// Handshake bundle between a FIFO's producer/consumer side and the
// gray_fifo_ctrl pointer controller.
interface gray_fifo_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              wr_req;
  logic              rd_req;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              unf;

  modport master (
    output wr_req, rd_req,
    input  wr_en, rd_en, wr_addr, rd_addr, wr_ptr_gray, rd_ptr_gray,
           full, empty, count, ovf, unf
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_en, rd_en, wr_addr, rd_addr, wr_ptr_gray, rd_ptr_gray,
           full, empty, count, ovf, unf
  );
endinterface

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller: binary pointers address storage, Gray
// copies are exported, and full/empty/count are registered from next-state pointers.
module gray_fifo_ctrl #(
  parameter int ADDR_W = 4
) (
  input logic             clk,
  input logic             rst,
  gray_fifo_ctrl_if.slave bus
);
  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] r_wrBin;
  logic [PW-1:0] r_rdBin;
  logic [PW-1:0] r_wrGray;
  logic [PW-1:0] r_rdGray;
  logic [PW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic          r_unf;

  logic          w_wrEn;
  logic          w_rdEn;
  logic [PW-1:0] w_wrBinNext;
  logic [PW-1:0] w_rdBinNext;
  logic [PW-1:0] w_wrGrayNext;
  logic [PW-1:0] w_rdGrayNext;
  logic          w_fullNext;
  logic          w_emptyNext;

  // Strobes are gated by the current flags, so a blocked request never moves a pointer.
  assign w_wrEn = bus.wr_req & ~r_full & ~rst;
  assign w_rdEn = bus.rd_req & ~r_empty & ~rst;

  assign w_wrBinNext  = r_wrBin + {{ADDR_W{1'b0}}, w_wrEn};
  assign w_rdBinNext  = r_rdBin + {{ADDR_W{1'b0}}, w_rdEn};
  assign w_wrGrayNext = w_wrBinNext ^ (w_wrBinNext >> 1);
  assign w_rdGrayNext = w_rdBinNext ^ (w_rdBinNext >> 1);

  // Full: write pointer is one lap ahead, which in Gray flips the top two bits.
  assign w_fullNext  = (w_wrGrayNext == {~w_rdGrayNext[PW-1:PW-2], w_rdGrayNext[PW-3:0]});
  assign w_emptyNext = (w_wrGrayNext == w_rdGrayNext);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrBin  <= '0;
      r_rdBin  <= '0;
      r_wrGray <= '0;
      r_rdGray <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wrBin  <= w_wrBinNext;
      r_rdBin  <= w_rdBinNext;
      r_wrGray <= w_wrGrayNext;
      r_rdGray <= w_rdGrayNext;
      r_count  <= w_wrBinNext - w_rdBinNext;
      r_full   <= w_fullNext;
      r_empty  <= w_emptyNext;
      r_ovf    <= r_ovf | (bus.wr_req & r_full);
      r_unf    <= r_unf | (bus.rd_req & r_empty);
    end
  end

  assign bus.wr_en       = w_wrEn;
  assign bus.rd_en       = w_rdEn;
  assign bus.wr_addr     = r_wrBin[ADDR_W-1:0];
  assign bus.rd_addr     = r_rdBin[ADDR_W-1:0];
  assign bus.wr_ptr_gray = r_wrGray;
  assign bus.rd_ptr_gray = r_rdGray;
  assign bus.count       = r_count;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.ovf         = r_ovf;
  assign bus.unf         = r_unf;
endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Directed bench for gray_fifo_ctrl (ADDR_W=4) with a small occupancy model
// and an independent bitwise Gray reference.
module tb_gray_fifo_ctrl;
  localparam int AW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [AW:0] mWr;
  logic [AW:0] mRd;
  logic        mOvf;
  logic        mUnf;

  gray_fifo_ctrl_if #(.ADDR_W(AW)) bus ();

  gray_fifo_ctrl #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW:0] grayOf(input logic [AW:0] b);
    return {b[4], b[4] ^ b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
  endfunction

  function automatic logic [AW:0] modelCount();
    logic [AW:0] c;
    c = mWr - mRd;
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_wgray"}, 32'(bus.wr_ptr_gray), 32'(grayOf(mWr)));
    checkOutput({tag, "_rgray"}, 32'(bus.rd_ptr_gray), 32'(grayOf(mRd)));
    checkOutput({tag, "_waddr"}, 32'(bus.wr_addr), 32'(mWr[AW-1:0]));
    checkOutput({tag, "_raddr"}, 32'(bus.rd_addr), 32'(mRd[AW-1:0]));
    checkOutput({tag, "_count"}, 32'(bus.count), 32'(modelCount()));
    checkOutput({tag, "_full"},  32'(bus.full),  32'(modelCount() == 5'd16));
    checkOutput({tag, "_empty"}, 32'(bus.empty), 32'(modelCount() == 5'd0));
    checkOutput({tag, "_ovf"},   32'(bus.ovf),   32'(mOvf));
    checkOutput({tag, "_unf"},   32'(bus.unf),   32'(mUnf));
  endtask

  // Each cycle: drive just after a rising edge, check strobes mid-cycle, check state after the next edge.
  task automatic applyStimulus(input logic wr, input logic rd, input int n);
    logic        mFull;
    logic        mEmpty;
    logic        doW;
    logic        doR;
    logic [AW:0] prevW;
    logic [AW:0] prevR;
    for (int i = 0; i < n; i++) begin
      bus.wr_req = wr;
      bus.rd_req = rd;
      mFull  = (modelCount() == 5'd16);
      mEmpty = (modelCount() == 5'd0);
      doW = wr & ~mFull;
      doR = rd & ~mEmpty;
      #2;
      checkOutput("wr_en", 32'(bus.wr_en), 32'(doW));
      checkOutput("rd_en", 32'(bus.rd_en), 32'(doR));
      prevW = bus.wr_ptr_gray;
      prevR = bus.rd_ptr_gray;
      if (wr && mFull)  mOvf = 1'b1;
      if (rd && mEmpty) mUnf = 1'b1;
      @(posedge clk);
      #1;
      if (doW) mWr = mWr + 5'd1;
      if (doR) mRd = mRd + 5'd1;
      checkState("step");
      if (doW) checkOutput("wgray_onebit", 32'($countones(bus.wr_ptr_gray ^ prevW)), 32'd1);
      if (doR) checkOutput("rgray_onebit", 32'($countones(bus.rd_ptr_gray ^ prevR)), 32'd1);
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
  endtask

  task automatic doReset(input logic wr);
    rst = 1'b1;
    bus.wr_req = wr;
    bus.rd_req = 1'b0;
    #2;
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_rd_en", 32'(bus.rd_en), 32'd0);
    @(posedge clk);
    #1;
    mWr = '0;
    mRd = '0;
    mOvf = 1'b0;
    mUnf = 1'b0;
    checkState("reset");
    rst = 1'b0;
    bus.wr_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mWr = '0;
    mRd = '0;
    mOvf = 1'b0;
    mUnf = 1'b0;
    rst = 1'b1;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    @(posedge clk);
    #1;
    doReset(1'b0);

    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("idle_empty", 32'(bus.empty), 32'd1);
    checkOutput("idle_wgray", 32'(bus.wr_ptr_gray), 32'h00);
    checkOutput("idle_rgray", 32'(bus.rd_ptr_gray), 32'h00);

    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b1, 1'b0, 16);
      applyStimulus(1'b0, 1'b1, 16);
    end
    checkOutput("lap_wgray", 32'(bus.wr_ptr_gray), 32'h00);

    applyStimulus(1'b1, 1'b0, 16);
    checkOutput("full_flag", 32'(bus.full), 32'd1);
    checkOutput("full_count", 32'(bus.count), 32'd16);
    checkOutput("full_wgray", 32'(bus.wr_ptr_gray), 32'h18);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("ovf_set", 32'(bus.ovf), 32'd1);
    checkOutput("ovf_wgray", 32'(bus.wr_ptr_gray), 32'h18);

    applyStimulus(1'b0, 1'b1, 16);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("unf_set", 32'(bus.unf), 32'd1);
    checkOutput("unf_count", 32'(bus.count), 32'd1);

    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, 20);
    checkOutput("conc_count", 32'(bus.count), 32'd5);

    applyStimulus(1'b1, 1'b0, 11);
    checkOutput("refull", 32'(bus.full), 32'd1);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("fullrw_count", 32'(bus.count), 32'd15);
    checkOutput("fullrw_full", 32'(bus.full), 32'd0);

    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("pre_rst_count", 32'(bus.count), 32'd9);
    doReset(1'b1);
    checkOutput("mid_rst_count", 32'(bus.count), 32'd0);
    checkOutput("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
